// File: rtl/tick_scheduler_pkg.sv
// ============================================================================
// Module      : tick_sched_pkg
// Description : Shared defaults and channel state encoding for tick_scheduler.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package tick_sched_pkg;

    localparam int CNT_W_DEF = 28;
    localparam int TAP_W_DEF = 5;
    localparam int CW_DEF    = 8;
    localparam int NCH_DEF   = 4;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_FIN  = 2'd2;

endpackage

`default_nettype wire

// File: rtl/tick_scheduler_channel.sv
// ============================================================================
// Module      : timer_channel
// Description : One timer channel; counts ticks of a selected prescaler tap.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module timer_channel
    import tick_sched_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF,
    parameter int TAP_W = TAP_W_DEF,
    parameter int CW    = CW_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start_i,
    input  logic             cancel_i,
    input  logic [TAP_W-1:0] tap_i,
    input  logic [CW-1:0]    count_i,
    input  logic [CNT_W-1:0] tick_i,
    output logic             busy_o,
    output logic             done_o
);

    logic [1:0]       state_q, state_d;
    logic [TAP_W-1:0] tap_q, tap_d;
    logic [CW-1:0]    rem_q, rem_d;
    logic             w_tick;
    logic             w_launch;

    assign w_tick   = tick_i[tap_q];
    assign w_launch = start_i && !cancel_i;

    always_comb begin
        state_d = state_q;
        tap_d   = tap_q;
        rem_d   = rem_q;
        if (cancel_i) begin
            state_d = ST_IDLE;
            rem_d   = '0;
        end else begin
            case (state_q)
                ST_IDLE, ST_FIN: begin
                    // FIN falls through to IDLE unless restarted in the same cycle
                    if (w_launch) begin
                        tap_d   = tap_i;
                        rem_d   = count_i;
                        state_d = (count_i == '0) ? ST_FIN : ST_RUN;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
                ST_RUN: begin
                    if (w_tick) begin
                        rem_d = rem_q - CW'(1);
                        if (rem_q == CW'(1)) begin
                            state_d = ST_FIN;
                        end
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    rem_d   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            tap_q   <= '0;
            rem_q   <= '0;
        end else begin
            state_q <= state_d;
            tap_q   <= tap_d;
            rem_q   <= rem_d;
        end
    end

    assign busy_o = (state_q == ST_RUN);
    assign done_o = (state_q == ST_FIN);

endmodule

`default_nettype wire

// File: rtl/tick_scheduler.sv
// ============================================================================
// Module      : tick_scheduler
// Description : Shared synchronous prescaler feeding NCH independent timers.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tick_scheduler
    import tick_sched_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF,
    parameter int TAP_W = TAP_W_DEF,
    parameter int CW    = CW_DEF,
    parameter int NCH   = NCH_DEF
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NCH-1:0]       start,
    input  logic [NCH-1:0]       cancel,
    input  logic [NCH*TAP_W-1:0] tap,
    input  logic [NCH*CW-1:0]    count,
    output logic [NCH-1:0]       busy,
    output logic [NCH-1:0]       done,
    output logic [CNT_W-1:0]     div_q
);

    localparam logic [TAP_W-1:0] TAP_MAX = TAP_W'(CNT_W - 1);

    logic [CNT_W-1:0] div_cnt_q, div_cnt_d;
    logic [CNT_W-1:0] w_tick;

    assign div_cnt_d = div_cnt_q + CNT_W'(1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt_q <= '0;
        end else begin
            div_cnt_q <= div_cnt_d;
        end
    end

    assign div_q = div_cnt_q;

    // tick[t] marks the cycle in which prescaler bit t has just risen
    for (genvar t = 0; t < CNT_W; t++) begin : g_tick
        if (t == 0) begin : g_lsb
            assign w_tick[t] = div_cnt_q[0];
        end else begin : g_bit
            assign w_tick[t] = div_cnt_q[t] & ~(|div_cnt_q[t-1:0]);
        end
    end

    for (genvar i = 0; i < NCH; i++) begin : g_ch
        logic [TAP_W-1:0] w_tap_raw;
        logic [TAP_W-1:0] w_tap_clamp;

        assign w_tap_raw   = tap[i*TAP_W +: TAP_W];
        assign w_tap_clamp = (w_tap_raw > TAP_MAX) ? TAP_MAX : w_tap_raw;

        timer_channel #(
            .CNT_W (CNT_W),
            .TAP_W (TAP_W),
            .CW    (CW)
        ) u_chan (
            .clk      (clk),
            .rst_n    (rst_n),
            .start_i  (start[i]),
            .cancel_i (cancel[i]),
            .tap_i    (w_tap_clamp),
            .count_i  (count[i*CW +: CW]),
            .tick_i   (w_tick),
            .busy_o   (busy[i]),
            .done_o   (done[i])
        );
    end

endmodule

`default_nettype wire

// File: tb/tb_tick_scheduler.sv
// ============================================================================
// Module      : tb_tick_scheduler
// Description : Self-checking bench for tick_scheduler (directed + random).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_tick_scheduler;
    import tick_sched_pkg::*;

    localparam int NCH   = NCH_DEF;
    localparam int CNT_W = CNT_W_DEF;
    localparam int TAP_W = TAP_W_DEF;
    localparam int CW    = CW_DEF;

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b1;
    logic [NCH-1:0]       start = '0;
    logic [NCH-1:0]       cancel = '0;
    logic [NCH*TAP_W-1:0] tap = '0;
    logic [NCH*CW-1:0]    count = '0;
    logic [NCH-1:0]       busy;
    logic [NCH-1:0]       done;
    logic [CNT_W-1:0]     div_q;

    tick_scheduler dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .cancel (cancel),
        .tap    (tap),
        .count  (count),
        .busy   (busy),
        .done   (done),
        .div_q  (div_q)
    );

    always #5 clk = ~clk;

    int             n_checks = 0;
    int             n_fail   = 0;
    longint         cyc;
    bit             act [NCH];
    longint         due [NCH];
    logic [NCH-1:0] smp_done;
    logic [NCH-1:0] smp_busy;
    longint         smp_cyc;

    typedef struct {
        logic [NCH-1:0]       st;
        logic [NCH*TAP_W-1:0] tp;
        logic [NCH*CW-1:0]    ct;
        logic [NCH-1:0]       eb;
        logic [NCH-1:0]       ed;
    } vec_t;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, got, exp);
        end
    endtask

    // Reference: done lands one cycle after the Nth tap tick strictly after the start cycle;
    // the tap ticks whenever cycle mod 2^(t+1) == 2^t (prescaler equals cycle count since reset).
    function automatic longint due_of(longint s, int t, int n);
        longint p;
        longint f;
        p = longint'(1) << (t + 1);
        f = s - (s % p) + p / 2;
        if (f <= s) f += p;
        return f + longint'(n - 1) * p + 1;
    endfunction

    task automatic model_clear();
        for (int c = 0; c < NCH; c++) begin
            act[c] = 1'b0;
            due[c] = 0;
        end
    endtask

    task automatic set_ch(input int ch, input bit st, input bit cn, input int tp, input int cnt);
        start[ch]                 = st;
        cancel[ch]                = cn;
        tap[ch*TAP_W +: TAP_W]    = TAP_W'(tp);
        count[ch*CW +: CW]        = CW'(cnt);
    endtask

    // Checks the current cycle against the model, then advances model and clock.
    task automatic step();
        logic [NCH-1:0] eb;
        logic [NCH-1:0] ed;
        int             t;
        int             n;
        @(negedge clk);
        for (int c = 0; c < NCH; c++) begin
            eb[c] = act[c] && (cyc < due[c]);
            ed[c] = act[c] && (cyc == due[c]);
        end
        smp_busy = busy;
        smp_done = done;
        smp_cyc  = cyc;
        chk("busy", 64'(busy), 64'(eb));
        chk("done", 64'(done), 64'(ed));
        chk("div_q", 64'(div_q), 64'(cyc[CNT_W-1:0]));
        for (int c = 0; c < NCH; c++) begin
            t = int'(tap[c*TAP_W +: TAP_W]);
            if (t >= CNT_W) t = CNT_W - 1;
            n = int'(count[c*CW +: CW]);
            if (cancel[c]) begin
                act[c] = 1'b0;
            end else if (start[c] && (!act[c] || cyc == due[c])) begin
                act[c] = 1'b1;
                due[c] = (n == 0) ? cyc + 1 : due_of(cyc, t, n);
            end else if (act[c] && cyc == due[c]) begin
                act[c] = 1'b0;
            end
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #2;
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_div", 64'(div_q), 64'd0);
        start  = '0;
        cancel = '0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        cyc   = 0;
        model_clear();
    endtask

    vec_t   tbl [8];
    longint dq [$];
    bit     seen;

    initial begin
        cyc = 0;
        model_clear();
        #2;
        do_reset();

        // ch0 tap0 count3 from an even prescaler value; ch1 count0
        tbl[0] = '{st: 4'b0011, tp: '0, ct: 32'h0000_0003, eb: 4'b0000, ed: 4'b0000};
        tbl[1] = '{st: 4'b0000, tp: '0, ct: '0, eb: 4'b0001, ed: 4'b0010};
        tbl[2] = '{st: 4'b0000, tp: '0, ct: '0, eb: 4'b0001, ed: 4'b0000};
        tbl[3] = '{st: 4'b0000, tp: '0, ct: '0, eb: 4'b0001, ed: 4'b0000};
        tbl[4] = '{st: 4'b0000, tp: '0, ct: '0, eb: 4'b0001, ed: 4'b0000};
        tbl[5] = '{st: 4'b0000, tp: '0, ct: '0, eb: 4'b0001, ed: 4'b0000};
        tbl[6] = '{st: 4'b0000, tp: '0, ct: '0, eb: 4'b0000, ed: 4'b0001};
        tbl[7] = '{st: 4'b0000, tp: '0, ct: '0, eb: 4'b0000, ed: 4'b0000};
        for (int i = 0; i < 8; i++) begin
            start = tbl[i].st;
            tap   = tbl[i].tp;
            count = tbl[i].ct;
            step();
            chk("tbl_busy", 64'(smp_busy), 64'(tbl[i].eb));
            chk("tbl_done", 64'(smp_done), 64'(tbl[i].ed));
        end

        // ch2 tap2 count5, cancelled after two ticks; then start+cancel together
        start = '0;
        set_ch(2, 1, 0, 2, 5);
        step();
        set_ch(2, 0, 0, 2, 5);
        repeat (17) step();
        set_ch(2, 0, 1, 2, 5);
        step();
        set_ch(2, 0, 0, 2, 5);
        seen = 1'b0;
        repeat (60) begin
            step();
            if (smp_done[2] || smp_busy[2]) seen = 1'b1;
        end
        chk("cancel_quiet", 64'(seen), 64'd0);
        set_ch(2, 1, 1, 2, 5);
        step();
        set_ch(2, 0, 0, 2, 5);
        step();
        chk("st_cn_idle", 64'(smp_busy[2]), 64'd0);

        // ch3: start in RUN ignored, then held start restarts every 2*2^2 cycles
        set_ch(3, 1, 0, 1, 2);
        step();
        set_ch(3, 1, 0, 1, 9);
        repeat (3) step();
        set_ch(3, 1, 0, 1, 2);
        repeat (40) begin
            step();
            if (smp_done[3]) dq.push_back(smp_cyc);
        end
        set_ch(3, 0, 0, 1, 2);
        repeat (10) step();
        chk("restart_cnt_ok", 64'(dq.size() >= 4), 64'd1);
        for (int i = 1; i < dq.size(); i++) begin
            chk("restart_gap", 64'(dq[i] - dq[i-1]), 64'd8);
        end

        // all channels tap1 count2 together
        for (int c = 0; c < NCH; c++) set_ch(c, 1, 0, 1, 2);
        step();
        for (int c = 0; c < NCH; c++) set_ch(c, 0, 0, 1, 2);
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            step();
            if (smp_done != '0) seen = 1'b1;
        end
        chk("all_done_seen", 64'(seen), 64'd1);
        chk("all_done", 64'(smp_done), 64'hF);
        repeat (2) step();

        // tap 31 clamps to the top tap: behaves like tap 27 over a short window
        set_ch(0, 1, 0, 31, 1);
        set_ch(1, 1, 0, 27, 1);
        step();
        set_ch(0, 0, 0, 31, 1);
        set_ch(1, 0, 0, 27, 1);
        repeat (300) step();
        chk("clamp_busy", 64'(smp_busy[1:0]), 64'h3);
        set_ch(0, 0, 1, 31, 1);
        set_ch(1, 0, 1, 27, 1);
        step();
        set_ch(0, 0, 0, 0, 0);
        set_ch(1, 0, 0, 0, 0);
        step();

        // randomized traffic, mid-run async reset, more traffic
        for (int pass = 0; pass < 2; pass++) begin
            for (int i = 0; i < 2500; i++) begin
                for (int c = 0; c < NCH; c++) begin
                    set_ch(c, ($urandom_range(0, 3) == 0), ($urandom_range(0, 31) == 0),
                           int'($urandom_range(0, 3)), int'($urandom_range(0, 5)));
                end
                step();
            end
            if (pass == 0) begin
                set_ch(0, 1, 0, 3, 5);
                step();
                start  = '0;
                cancel = '0;
                step();
                chk("pre_rst_busy", 64'(smp_busy[0]), 64'd1);
                do_reset();
                repeat (4) step();
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
